// File: rtl/fft_pease_helpers_pkg.sv
// fft_pease_helpers_pkg: state encoding and saturating negate shared by the pease FFT helpers.
package fft_pease_helpers_pkg;

    typedef enum logic [0:0] {
        LOAD = 1'b0,
        DONE = 1'b1
    } state_t;

    localparam int MAX_W = 64;

    // Width-generic: callers zero-extend to MAX_W, pass their real width and truncate the result.
    function automatic logic [MAX_W-1:0] neg_sat(input logic [MAX_W-1:0] s, input int unsigned w);
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] min_neg;
        logic [MAX_W-1:0] v;
        mask    = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
        min_neg = MAX_W'(1) << (w - 1);
        v       = s & mask;
        return (v == min_neg) ? (min_neg - MAX_W'(1)) : ((~v + MAX_W'(1)) & mask);
    endfunction

endpackage

// File: rtl/fft_pease_helpers_sine_table_builder.sv
// fft_pease_helpers_sine_table_builder: expands a streamed quarter-wave into a full-period sine table.
module fft_pease_helpers_sine_table_builder
    import fft_pease_helpers_pkg::*;
#(
    parameter int BIT_WIDTH  = 32,
    parameter int DECIMAL_PT = 16,
    parameter int SIZE_FFT   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BIT_WIDTH-1:0] recv_msg,
    input  logic                 recv_val,
    output logic                 recv_rdy,
    input  logic                 clear,
    output logic [BIT_WIDTH-1:0] sine_wave_out [SIZE_FFT],
    output logic                 send_val
);

    localparam int IW = $clog2(SIZE_FFT);
    localparam int KW = $clog2(SIZE_FFT / 4 + 1);
    localparam logic [IW-1:0] HALF = IW'(SIZE_FFT / 2);
    localparam logic [KW-1:0] QTR  = KW'(SIZE_FFT / 4);

    if (SIZE_FFT < 4 || (SIZE_FFT & (SIZE_FFT - 1)) != 0 || DECIMAL_PT >= BIT_WIDTH) begin : g_param_check
        $error("sine_table_builder: SIZE_FFT must be a power of two >= 4 and DECIMAL_PT < BIT_WIDTH");
    end

    state_t               state;
    logic [KW-1:0]        k;
    logic [IW-1:0]        i_lo;
    logic [IW-1:0]        i_mir;
    logic [IW-1:0]        i_neg;
    logic [IW-1:0]        i_wrap;
    logic [BIT_WIDTH-1:0] s_neg;
    logic                 xfer;

    assign recv_rdy = (state == LOAD) && !clear;
    assign xfer     = recv_val && recv_rdy;
    assign send_val = state == DONE;

    // Index arithmetic wraps naturally in IW bits, giving the mod SIZE_FFT for free.
    always_comb begin
        i_lo   = IW'(k);
        i_mir  = HALF - i_lo;
        i_neg  = HALF + i_lo;
        i_wrap = -i_lo;
        s_neg  = BIT_WIDTH'(neg_sat(MAX_W'(recv_msg), BIT_WIDTH));
    end

    // Write order sets collision priority: the last assignment to an entry wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= LOAD;
            k     <= '0;
            for (int m = 0; m < SIZE_FFT; m++) sine_wave_out[m] <= '0;
        end else if (clear) begin
            state <= LOAD;
            k     <= '0;
        end else if (xfer) begin
            sine_wave_out[i_lo]   <= recv_msg;
            sine_wave_out[i_mir]  <= recv_msg;
            sine_wave_out[i_neg]  <= s_neg;
            sine_wave_out[i_wrap] <= s_neg;
            state <= (k == QTR) ? DONE : LOAD;
            k     <= (k == QTR) ? '0 : k + 1'b1;
        end
    end

endmodule
